// File: rtl/change_dispenser.sv
// change_dispenser: pays out a settled sale. Tickets are issued one per
// ticket_ack handshake, then change is paid one coin per coin_ack using a
// greedy largest-coin-first choice against per-denomination coin stock.
// Build option: define CHANGE_DISP_FIFTY_EN to add the 50 coin and its stock
// counter; without it only 10/5/1 coins exist.
module change_dispenser #(
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [6:0] change_in,
    input  logic [2:0] sheet_in,
    input  logic       refill,
    input  logic       ticket_ack,
    input  logic       coin_ack,
    output logic       ticket_valid,
    output logic       coin_valid,
    output logic [5:0] coin_val,
    output logic [6:0] remaining,
    output logic       busy,
    output logic       done,
    output logic       short
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TICKET,
        S_SELECT,
        S_COIN,
        S_DONE,
        S_SHORT
    } state_t;

    // Stock counters saturate at their full-scale value, so an oversized
    // STOCK_INIT is clamped rather than wrapped.
    localparam int STOCK_MAX  = (1 << STOCK_W) - 1;
    localparam int INIT_CLAMP = (STOCK_INIT > STOCK_MAX) ? STOCK_MAX : STOCK_INIT;
    localparam logic [STOCK_W-1:0] STOCK_RST = STOCK_W'(INIT_CLAMP);

    state_t             state;
    logic [2:0]         tickets;
    logic [5:0]         sel_val;
    logic [STOCK_W-1:0] stock_1;
    logic [STOCK_W-1:0] stock_5;
    logic [STOCK_W-1:0] stock_10;
`ifdef CHANGE_DISP_FIFTY_EN
    logic [STOCK_W-1:0] stock_50;
`endif

    // Decrement that holds at zero; stock can never wrap below empty.
    function automatic logic [STOCK_W-1:0] stock_dec(input logic [STOCK_W-1:0] s);
        return (s == '0) ? s : s - 1'b1;
    endfunction

    // Greedy coin choice: later tests override earlier ones, so the largest
    // affordable denomination that is still in stock wins; 0 means none.
    always_comb begin
        sel_val = 6'd0;
        if (remaining >= 7'd1 && stock_1 != '0)
            sel_val = 6'd1;
        if (remaining >= 7'd5 && stock_5 != '0)
            sel_val = 6'd5;
        if (remaining >= 7'd10 && stock_10 != '0)
            sel_val = 6'd10;
`ifdef CHANGE_DISP_FIFTY_EN
        if (remaining >= 7'd50 && stock_50 != '0)
            sel_val = 6'd50;
`endif
    end

    // Payout sequencer with registered handshake and status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            remaining    <= '0;
            tickets      <= '0;
            stock_1      <= STOCK_RST;
            stock_5      <= STOCK_RST;
            stock_10     <= STOCK_RST;
`ifdef CHANGE_DISP_FIFTY_EN
            stock_50     <= STOCK_RST;
`endif
            ticket_valid <= 1'b0;
            coin_valid   <= 1'b0;
            coin_val     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            short        <= 1'b0;
        end else begin
            done  <= 1'b0;
            short <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (refill) begin
                        stock_1  <= STOCK_RST;
                        stock_5  <= STOCK_RST;
                        stock_10 <= STOCK_RST;
`ifdef CHANGE_DISP_FIFTY_EN
                        stock_50 <= STOCK_RST;
`endif
                    end
                    if (load) begin
                        remaining <= change_in;
                        tickets   <= sheet_in;
                        busy      <= 1'b1;
                        if (sheet_in != 3'd0) begin
                            ticket_valid <= 1'b1;
                            state        <= S_TICKET;
                        end else begin
                            state <= S_SELECT;
                        end
                    end
                end
                S_TICKET: begin
                    if (ticket_ack) begin
                        tickets <= tickets - 3'd1;
                        if (tickets == 3'd1) begin
                            ticket_valid <= 1'b0;
                            state        <= S_SELECT;
                        end
                    end
                end
                S_SELECT: begin
                    if (remaining == 7'd0) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (sel_val != 6'd0) begin
                        coin_valid <= 1'b1;
                        coin_val   <= sel_val;
                        state      <= S_COIN;
                    end else begin
                        short <= 1'b1;
                        state <= S_SHORT;
                    end
                end
                S_COIN: begin
                    if (coin_ack) begin
                        // coin_val never exceeds remaining, so no underflow here
                        remaining <= remaining - 7'(coin_val);
                        case (coin_val)
                            6'd1:    stock_1  <= stock_dec(stock_1);
                            6'd5:    stock_5  <= stock_dec(stock_5);
                            6'd10:   stock_10 <= stock_dec(stock_10);
`ifdef CHANGE_DISP_FIFTY_EN
                            6'd50:   stock_50 <= stock_dec(stock_50);
`endif
                            default: ;
                        endcase
                        coin_valid <= 1'b0;
                        coin_val   <= '0;
                        state      <= S_SELECT;
                    end
                end
                S_DONE, S_SHORT: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    ticket_valid <= 1'b0;
                    coin_valid   <= 1'b0;
                    coin_val     <= '0;
                    busy         <= 1'b0;
                    state        <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Output-side companion to the ticket seller: accepts the settled sale (ticket count and change owed) and physically pays it out. Issues tickets one per handshake, then dispenses change as individual coins with a greedy largest-coin-first policy against per-denomination coin stock. Sits between the seller's `change`/`sheet_out` results and the ticket/coin hopper drivers.

## Interface
- `STOCK_W`, 4: width of each coin-stock counter; counters saturate at 2^STOCK_W-1.
- `STOCK_INIT`, 8: value loaded into every stock counter on reset and on refill.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `load` in 1: start a payout; sampled only in IDLE.
- `change_in` in 7: change owed, 0..127.
- `sheet_in` in 3: tickets to issue, 0..7.
- `refill` in 1: restore all stock counters to STOCK_INIT; honoured only in IDLE.
- `ticket_ack` in 1: hopper took one ticket.
- `coin_ack` in 1: hopper took one coin.
- `ticket_valid` out 1: one ticket offered.
- `coin_valid` out 1: one coin offered.
- `coin_val` out 6: denomination of offered coin (1, 5, 10, 50).
- `remaining` out 7: change still owed.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse, payout complete.
- `short` out 1: one-cycle pulse, exact change impossible.

## Operation
- States: IDLE, TICKET, SELECT, COIN, DONE, SHORT.
- IDLE: `load`=1 latches `change_in` into `remaining` and `sheet_in` into ticket counter; next state TICKET if `sheet_in`≠0, else SELECT. `refill` and `load` in the same cycle: both applied.
- TICKET: `ticket_valid`=1 held until `ticket_ack`; each ack decrements ticket counter; ack on last ticket -> SELECT.
- SELECT (one cycle, no outputs asserted): `remaining`==0 -> DONE; else choose largest denomination d with d ≤ `remaining` and stock[d]>0 -> COIN; none -> SHORT.
- COIN: `coin_valid`=1, `coin_val`=d, held stable until `coin_ack`; on ack `remaining` -= d, stock[d] -= 1, -> SELECT.
- DONE: `done`=1 one cycle -> IDLE.
- SHORT: `short`=1 one cycle -> IDLE; `remaining` keeps the unpaid amount until next `load` or reset.
- `load` outside IDLE ignored; inputs not re-sampled. `refill` outside IDLE ignored (not queued).
- `ticket_ack`/`coin_ack` outside their states ignored.
- Arithmetic: `remaining` never underflows (d ≤ `remaining` by construction); stock never decremented below 0.

## Timing
- Reset values: state IDLE, `remaining`=0, ticket counter 0, all stock = STOCK_INIT, all outputs 0 (`coin_val`=0).
- `load` at edge N -> `busy`=1 and `ticket_valid` (or SELECT) from N+1.
- Ack seen at edge N in COIN -> SELECT at N+1 -> next `coin_valid` at N+2; minimum 2 cycles per coin, 1 cycle per ticket if ack held high.
- `load` with 0 tickets, 0 change: SELECT at N+1, `done` at N+2, IDLE at N+3.
- Reset mid-payout: immediate return to IDLE, outputs cleared, stock restored to STOCK_INIT; partially paid amount is lost.

## Configuration
- `CHANGE_DISP_FIFTY_EN` defined: denominations 50/10/5/1, four stock counters.
- Undefined: denominations 10/5/1 only; 50 never appears on `coin_val`; no 50 counter built.

## Test plan
- `change_in`=37, `sheet_in`=3, acks held high -> 3 tickets, then coins 10,10,10,5,1,1, `done` pulse, `remaining`=0.
- With FIFTY_EN, `change_in`=66, `sheet_in`=1 -> 1 ticket, coins 50,10,5,1, `done`.
- STOCK_INIT=2, `change_in`=37, `sheet_in`=0 -> coins 10,10,5,5,1,1, `short` pulse, `remaining`=5; `refill` then `load` 5 -> coin 5, `done`.
- `coin_ack` delayed 4 cycles -> `coin_valid`/`coin_val` stable throughout; second `load` during payout ignored.
- `reset` asserted while `coin_valid`=1 -> all outputs 0 same cycle, `busy`=0, stock back to STOCK_INIT.
- `change_in`=0, `sheet_in`=0 -> `done` exactly 2 cycles after `load`, no ticket/coin offered.
